// File: rtl/ram_arbiter_if.sv
// Request/grant bundle between the requesting ports and the round-robin RAM arbiter.
// Handshake: a port raises req_i[n] and holds it for its whole ownership period.
// Ownership starts on the cycle grant_o[n] is seen high and ends the cycle after req_i[n] drops.
interface ram_arbiter_if #(
   parameter int NUM_PORTS = 6,
   parameter int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
   logic [NUM_PORTS-1:0] req_i;
   logic [NUM_PORTS-1:0] grant_o;
   logic [SEL_WIDTH-1:0] select_o;
   logic                 active_o;

   modport master (
      output req_i,
      input  grant_o,
      input  select_o,
      input  active_o
   );

   modport slave (
      input  req_i,
      output grant_o,
      output select_o,
      output active_o
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter granting exclusive ownership of the RAM (via ram_mux select/active)
// to one requester at a time, with an optional hold limit that forces rotation.
module ram_arbiter #(
   parameter int NUM_PORTS = 6,
   parameter int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   parameter int MAX_HOLD  = 0
) (
   input  logic          clk_i,
   input  logic          reset_i,
   ram_arbiter_if.slave  bus,
   output logic          dbg_state_o
);

   localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int EXP_AT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [NUM_PORTS-1:0] r_grant;
   logic [SEL_WIDTH-1:0] r_sel;
   logic [SEL_WIDTH-1:0] r_last;
   logic                 r_active;
   logic [HOLD_W-1:0]    r_hold;
   logic [HOLD_W-1:0]    w_hold_next;

   logic                 w_any_req;
   logic                 w_others;
   logic                 w_owner_req;
   logic                 w_expired;
   logic                 w_load;
   logic                 w_release;
   logic [SEL_WIDTH-1:0] w_winner;
   logic [NUM_PORTS-1:0] w_win_onehot;

   // First requester after r_last, wrapping; r_last itself is therefore searched last.
   function automatic logic [SEL_WIDTH-1:0] f_pick(input logic [NUM_PORTS-1:0] req,
                                                    input logic [SEL_WIDTH-1:0] last);
      logic found;
      int   idx;
      f_pick = '0;
      found  = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = (int'(last) + i) % NUM_PORTS;
         if (!found && req[idx]) begin
            found  = 1'b1;
            f_pick = SEL_WIDTH'(idx);
         end
      end
   endfunction

   assign w_any_req    = |bus.req_i;
   assign w_others     = |(bus.req_i & ~r_grant);
   assign w_owner_req  = bus.req_i[r_sel];
   assign w_expired    = (MAX_HOLD != 0) && (int'(r_hold) >= EXP_AT);
   assign w_winner     = f_pick(bus.req_i, r_last);
   assign w_win_onehot = NUM_PORTS'(1) << w_winner;

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_release    = 1'b0;
      w_hold_next  = r_hold;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_load       = 1'b1;
               w_hold_next  = '0;
               w_next_state = S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_owner_req) begin
               if (w_expired && w_others) begin
                  w_load      = 1'b1;
                  w_hold_next = '0;
               end else if (w_expired) begin
                  w_hold_next = '0;
               end else begin
                  w_hold_next = (r_hold == HOLD_SAT) ? r_hold : r_hold + 1'b1;
               end
            end else if (w_any_req) begin
               w_load      = 1'b1;
               w_hold_next = '0;
            end else begin
               // select_o deliberately keeps the last owner's index while idle.
               w_release    = 1'b1;
               w_hold_next  = '0;
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_sel    <= '0;
         r_active <= 1'b0;
         r_last   <= SEL_WIDTH'(NUM_PORTS - 1);
         r_hold   <= '0;
      end else begin
         r_state <= w_next_state;
         r_hold  <= w_hold_next;
         if (w_load) begin
            r_grant  <= w_win_onehot;
            r_sel    <= w_winner;
            r_last   <= w_winner;
            r_active <= 1'b1;
         end else if (w_release) begin
            r_grant  <= '0;
            r_active <= 1'b0;
         end
      end
   end

   assign bus.grant_o  = r_grant;
   assign bus.select_o = r_sel;
   assign bus.active_o = r_active;
   assign dbg_state_o  = r_state;

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (r_active == (|r_grant)) else $error("active/grant disagree");
         assert (r_grant[r_sel] == r_active) else $error("grant/select disagree");
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (unlimited hold and MAX_HOLD=4) driven with the
// same requests and compared against a cycle-level reference model of the arbitration rules.
module tb_ram_arbiter;

   localparam int N  = 6;
   localparam int SW = 3;
   localparam int W  = N + SW + 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic         dbg0;
   logic         dbg1;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];

   ram_arbiter_if #(.NUM_PORTS(N), .SEL_WIDTH(SW)) bus0 ();
   ram_arbiter_if #(.NUM_PORTS(N), .SEL_WIDTH(SW)) bus1 ();

   assign bus0.req_i = req;
   assign bus1.req_i = req;

   ram_arbiter #(.NUM_PORTS(N), .SEL_WIDTH(SW), .MAX_HOLD(0)) dut0 (
      .clk_i       (clk),
      .reset_i     (rst),
      .bus         (bus0),
      .dbg_state_o (dbg0)
   );

   ram_arbiter #(.NUM_PORTS(N), .SEL_WIDTH(SW), .MAX_HOLD(4)) dut1 (
      .clk_i       (clk),
      .reset_i     (rst),
      .bus         (bus1),
      .dbg_state_o (dbg1)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // owner = -1 means idle; held = number of grant cycles the current owner has had so far.
   int m_owner[2];
   int m_last[2];
   int m_sel[2];
   int m_held[2];
   int m_max[2] = '{0, 4};

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int i = 1; i <= N; i++) begin
         if (r[(last + i) % N]) return (last + i) % N;
      end
      return -1;
   endfunction

   function automatic void model_step(input logic [N-1:0] r, input logic rs);
      int p;
      for (int k = 0; k < 2; k++) begin
         p = pick(r, m_last[k]);
         if (rs) begin
            m_owner[k] = -1; m_last[k] = N - 1; m_sel[k] = 0; m_held[k] = 0;
         end else if (m_owner[k] < 0 || !r[m_owner[k]]) begin
            if (p >= 0) begin
               m_owner[k] = p; m_last[k] = p; m_sel[k] = p; m_held[k] = 1;
            end else begin
               m_owner[k] = -1;
            end
         end else if (m_max[k] != 0 && m_held[k] >= m_max[k]) begin
            if (p != m_owner[k]) begin
               m_owner[k] = p; m_last[k] = p; m_sel[k] = p; m_held[k] = 1;
            end else begin
               m_held[k] = 1;
            end
         end else begin
            m_held[k]++;
         end
      end
   endfunction

   function automatic logic [W-1:0] exp_obs(input int k);
      logic [N-1:0] g;
      g = (m_owner[k] >= 0) ? (N'(1) << m_owner[k]) : '0;
      return {g, SW'(m_sel[k]), (m_owner[k] >= 0)};
   endfunction

   function automatic logic [W-1:0] obs(input int k);
      if (k == 0) return {bus0.grant_o, bus0.select_o, bus0.active_o};
      return {bus1.grant_o, bus1.select_o, bus1.active_o};
   endfunction

   function automatic logic [SW-1:0] sel_of(input int k);
      return (k == 0) ? bus0.select_o : bus1.select_o;
   endfunction

   // ---------------- driver ----------------
   task automatic tick(input logic [N-1:0] r, input logic rs);
      req = r;
      rst = rs;
      @(posedge clk);
      model_step(r, rs);
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      tick('0, 1'b1);
      tick('0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== '0) begin
            failures++;
            $display("FAIL reset_outputs dut%0d got=%h exp=0", k, obs(k));
         end
         checks++;
         if (obs(k) !== exp_obs(k)) begin
            failures++;
            $display("FAIL reset_model dut%0d got=%h exp=%h", k, obs(k), exp_obs(k));
         end
      end
      checks++;
      if ({dbg0, dbg1} !== 2'b00) begin
         failures++;
         $display("FAIL reset_state got=%b exp=00", {dbg0, dbg1});
      end
   endtask

   task automatic test_single();
      tick('0, 1'b1);
      tick(6'b000001, 1'b0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== {6'b000001, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_grant dut%0d got=%h exp=%h", k, obs(k), {6'b000001, 3'd0, 1'b1});
         end
      end
      checks++;
      if ({dbg0, dbg1} !== 2'b11) begin
         failures++;
         $display("FAIL busy_state got=%b exp=11", {dbg0, dbg1});
      end
   endtask

   task automatic test_back_to_back();
      tick('0, 1'b1);
      tick(6'b100100, 1'b0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== {6'b000100, 3'd2, 1'b1}) begin
            failures++;
            $display("FAIL b2b_first dut%0d got=%h exp=%h", k, obs(k), {6'b000100, 3'd2, 1'b1});
         end
      end
      tick(6'b100000, 1'b0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== {6'b100000, 3'd5, 1'b1}) begin
            failures++;
            $display("FAIL b2b_second dut%0d got=%h exp=%h", k, obs(k), {6'b100000, 3'd5, 1'b1});
         end
      end
   endtask

   task automatic test_rotation();
      int order[7] = '{0, 1, 2, 3, 4, 5, 0};
      int cur;
      tick('0, 1'b1);
      tick(6'b111111, 1'b0);
      cur = 0;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) tick(6'b111111 & ~(N'(1) << cur), 1'b0);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (sel_of(k) !== SW'(order[i]) || obs(k) !== exp_obs(k)) begin
               failures++;
               $display("FAIL rotation step%0d dut%0d got=%h exp_sel=%0d model=%h",
                        i, k, obs(k), order[i], exp_obs(k));
            end
         end
         cur = order[i];
      end
   endtask

   task automatic test_hold_limit();
      int exp_sel1[5] = '{1, 1, 1, 1, 3};
      tick('0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         tick((c == 0) ? 6'b000010 : 6'b001010, 1'b0);
         checks++;
         if (bus1.select_o !== SW'(exp_sel1[c]) || bus1.active_o !== 1'b1) begin
            failures++;
            $display("FAIL hold_limit cycle%0d got_sel=%0d exp_sel=%0d", c, bus1.select_o, exp_sel1[c]);
         end
         checks++;
         if (bus0.select_o !== 3'd1) begin
            failures++;
            $display("FAIL hold_unlimited cycle%0d got_sel=%0d exp_sel=1", c, bus0.select_o);
         end
      end
      tick('0, 1'b1);
      for (int c = 0; c < 12; c++) begin
         tick(6'b000010, 1'b0);
         checks++;
         if (obs(1) !== {6'b000010, 3'd1, 1'b1}) begin
            failures++;
            $display("FAIL hold_alone cycle%0d got=%h exp=%h", c, obs(1), {6'b000010, 3'd1, 1'b1});
         end
      end
   endtask

   task automatic test_idle_drop();
      tick('0, 1'b1);
      tick(6'b000100, 1'b0);
      tick('0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== {6'b000000, 3'd2, 1'b0}) begin
            failures++;
            $display("FAIL idle_drop dut%0d got=%h exp=%h", k, obs(k), {6'b000000, 3'd2, 1'b0});
         end
      end
      checks++;
      if ({dbg0, dbg1} !== 2'b00) begin
         failures++;
         $display("FAIL idle_state got=%b exp=00", {dbg0, dbg1});
      end
   endtask

   task automatic test_reset_mid();
      tick('0, 1'b1);
      tick(6'b010000, 1'b0);
      tick(6'b010000, 1'b0);
      checks++;
      if (bus0.select_o !== 3'd4 || bus1.select_o !== 3'd4) begin
         failures++;
         $display("FAIL mid_owner got=%0d/%0d exp=4", bus0.select_o, bus1.select_o);
      end
      tick(6'b111111, 1'b1);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== '0) begin
            failures++;
            $display("FAIL mid_reset dut%0d got=%h exp=0", k, obs(k));
         end
      end
      tick(6'b111111, 1'b0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== {6'b000001, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL post_reset_grant dut%0d got=%h exp=%h", k, obs(k), {6'b000001, 3'd0, 1'b1});
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic         rs;
      logic [W-1:0] e;
      tick('0, 1'b1);
      r = '0;
      for (int c = 0; c < 600; c++) begin
         r  = r ^ N'($urandom & $urandom);
         rs = ($urandom_range(0, 59) == 0);
         tick(r, rs);
         exp_q.push_back(exp_obs(0));
         exp_q.push_back(exp_obs(1));
         for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs(k) !== e) begin
               failures++;
               $display("FAIL random cycle%0d dut%0d req=%b got=%h exp=%h", c, k, r, obs(k), e);
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_owner[k] = -1; m_last[k] = N - 1; m_sel[k] = 0; m_held[k] = 0;
      end
      test_reset();
      test_single();
      test_back_to_back();
      test_rotation();
      test_hold_limit();
      test_idle_drop();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
